lfsr_seq_ctrl: RTL and testbench
================================

Name: lfsr_seq_ctrl

Overview:
- Sequencer for a Fibonacci LFSR pattern source.
- Holds a programmable seed and, on start, loads the seed into the LFSR.
- Streams exactly len LFSR states over a valid/ready interface, then pulses done.
- Used wherever a test-pattern or PRBS burst of known length is needed, for example BIST stimulus or scrambler seeding.

Parameters:
- WIDTH, 4, LFSR width in bits.
- TAPS, 4'b0011, feedback mask: fb = XOR of r[i] where TAPS[i]=1.
- CNT_W, 8, width of the burst-length counter.
- DEFAULT_SEED, 1, seed register and LFSR value after reset. Must be nonzero.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  seed write strobe.
- cfg_seed  in  WIDTH  seed value, sampled when cfg_we=1.
- seed_err  out  1  one-cycle pulse: a seed write was rejected because cfg_seed was 0.
- start  in  1  begin a burst. Sampled only in IDLE.
- len  in  CNT_W  number of beats in the burst. Sampled together with start.
- abort  in  1  terminate the current burst.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the beat.
- out_data  out  WIDTH  current LFSR state.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at normal burst completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; seed_reg and lfsr = DEFAULT_SEED; beat counter = 0; len_reg = 0.
  - out_valid, busy, done and seed_err = 0; out_data = DEFAULT_SEED.
- LFSR step:
  - fb = XOR(lfsr & TAPS); lfsr_next = {fb, lfsr[WIDTH-1:1]}.
  - The LFSR advances only on a handshake (out_valid & out_ready). Otherwise it holds.
- Seed write:
  - cfg_we=1 with cfg_seed != 0: seed_reg updates next edge. This is legal in any state and takes effect at the next start, never mid-burst.
  - cfg_we=1 with cfg_seed == 0: seed_reg unchanged; seed_err=1 on the next cycle for one cycle.
- State machine (IDLE, RUN, DONE):
  - IDLE, start=1, len != 0: next cycle lfsr <= seed_reg, len_reg <= len, count <= 0, state=RUN. Latency from start to first out_valid is 1 cycle.
  - IDLE, start=1, len == 0: state=DONE directly. No beat is produced and the LFSR is untouched.
  - RUN: out_valid=1, busy=1, out_data=lfsr.
    - On a handshake: count increments and the LFSR steps.
    - A handshake with count == len_reg-1 moves to DONE.
    - out_data is stable while out_valid=1 and out_ready=0.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. The LFSR keeps its last stepped value.
- abort:
  - abort=1 in RUN: state=IDLE next cycle; done is not asserted.
  - A handshake in the abort cycle is a completed transfer for the sink and the LFSR steps. Counter state is discarded.
  - abort in IDLE or DONE has no effect.
  - abort takes priority over last-beat completion in the same cycle: the block goes to IDLE, with no done.
- start while in RUN or DONE is ignored; it is not queued.
- Counter width: len up to 2^CNT_W-1. No wrap occurs inside a burst. If len exceeds the LFSR period (2^WIDTH-1), the sequence simply repeats.
- Reset asserted mid-burst returns all state to reset values immediately; no done pulse.

Decomposition:
- Package lfsr_pkg holds:
  - state enum type lfsr_seq_state_t {IDLE, RUN, DONE};
  - the default TAPS constant;
  - DEFAULT_SEED.
- Sub-module lfsr_core holds the LFSR register and feedback logic.
  - Parameters: WIDTH, TAPS, DEFAULT_SEED.
  - Ports: clk, reset, load, load_val, step, q.
  - load has priority over step.
- The controller owns the FSM, counter, seed register and handshake logic.

Test Plan:
- Default seed, len=5, out_ready=1, pulse start → out_valid goes high 1 cycle after start; beats 1,8,4,2,9 on consecutive cycles; done pulses the cycle after the 5th beat; busy falls with done.
- Same burst with out_ready toggling 1,0,0,1,0,1,… → out_data holds across stalls; the accepted beats are still exactly 1,8,4,2,9; done follows the 5th accepted beat.
- cfg_we with cfg_seed=0, then start with len=2 → seed_err pulses once; beats are 1,8, so the seed is unchanged.
  - Then cfg_we with seed=4'b1010 → the next burst starts with beat 10.
- start with len=0 → no out_valid at any point; done=1 on the cycle after start; LFSR value unchanged.
- len=20, abort asserted with the 3rd beat's handshake → 3 beats transferred; IDLE next cycle; out_valid=0; no done.
  - A second start during the aborted run is ignored.
- Seed 1, len=15, out_ready=1 → 15 distinct nonzero values; LFSR equals 1 after the burst.
  - Repeat the burst, drive reset low mid-burst → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR burst sequencer.
// Contents: controller state type, default feedback taps and default seed.
package lfsr_pkg;

  localparam int unsigned LfsrWidth   = 4;
  localparam int unsigned DefaultCntW = 8;

  // x^4 + x^3 + 1 in this right-shifting form: fb = r[0] ^ r[1], maximal length.
  localparam logic [LfsrWidth-1:0] DefaultTaps = 4'b0011;
  // Any nonzero value works; zero would lock the LFSR.
  localparam logic [LfsrWidth-1:0] DefaultSeed = 4'd1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } lfsr_seq_state_t;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Bundle of the sequencer's configuration, control and stream signals.
// master: sequencer side (drives seed_err, out_valid, out_data, busy, done).
// slave:  user side (drives cfg_we, cfg_seed, start, len, abort, out_ready).
interface lfsr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
);

  logic             cfg_we;
  logic [WIDTH-1:0] cfg_seed;
  logic             seed_err;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;

  modport master (
    input  cfg_we, cfg_seed, start, len, abort, out_ready,
    output seed_err, out_valid, out_data, busy, done
  );

  modport slave (
    output cfg_we, cfg_seed, start, len, abort, out_ready,
    input  seed_err, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register with parallel load.
// Ports: clk, reset (async, active-low), load/load_val (load has priority),
//        step (advance one state), q (current state).
module lfsr_core import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH        = LfsrWidth,
  parameter logic [WIDTH-1:0] TAPS         = DefaultTaps,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DefaultSeed
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             fb;

  always_comb begin
    fb     = ^(lfsr_q & TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = load_val;
    end else if (step) begin
      lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= DEFAULT_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR burst sequencer: holds a seed, loads it on start and streams exactly
// len LFSR states over valid/ready, then pulses done for one cycle.
// Ports: clk, reset (async, active-low), bus_io (lfsr_seq_ctrl_if.master):
//   cfg_we/cfg_seed -> seed write, seed_err on a rejected zero seed;
//   start/len/abort -> burst control; out_valid/out_ready/out_data -> stream;
//   busy (in RUN), done (one-cycle completion pulse).
module lfsr_seq_ctrl import lfsr_pkg::*; #(
  parameter int unsigned      WIDTH        = LfsrWidth,
  parameter logic [WIDTH-1:0] TAPS         = DefaultTaps,
  parameter int unsigned      CNT_W        = DefaultCntW,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = DefaultSeed
) (
  input logic              clk,
  input logic              reset,
  lfsr_seq_ctrl_if.master  bus_io
);

  lfsr_seq_state_t  state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             seed_err_q, seed_err_d;
  logic             launch;
  logic             hs;
  logic [WIDTH-1:0] lfsr;

  // A zero-length start skips RUN, so only a nonzero len reloads the LFSR.
  assign launch = (state_q == StIdle) && bus_io.start && (bus_io.len != '0);
  assign hs     = (state_q == StRun) && bus_io.out_ready;

  // Seed register: zero seeds are rejected and flagged one cycle later.
  always_comb begin
    seed_d     = seed_q;
    seed_err_d = 1'b0;
    if (bus_io.cfg_we) begin
      if (bus_io.cfg_seed != '0) begin
        seed_d = bus_io.cfg_seed;
      end else begin
        seed_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (bus_io.len != '0) begin
            state_d = StRun;
            len_d   = bus_io.len;
            cnt_d   = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        // Abort wins over completion of the last beat.
        if (bus_io.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      seed_q     <= DEFAULT_SEED;
      cnt_q      <= '0;
      len_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      seed_err_q <= seed_err_d;
    end
  end

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (launch),
    .load_val (seed_q),
    .step     (hs),
    .q        (lfsr)
  );

  assign bus_io.out_valid = (state_q == StRun);
  assign bus_io.busy      = (state_q == StRun);
  assign bus_io.done      = (state_q == StDone);
  assign bus_io.out_data  = lfsr;
  assign bus_io.seed_err  = seed_err_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: vector table, directed corner
// sequences and a randomized burst phase against a burst-level model.
module tb_lfsr_seq_ctrl;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;
  localparam logic [W-1:0] Taps = 4'b0011;

  logic clk = 1'b0;
  logic reset = 1'b0;

  lfsr_seq_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  lfsr_seq_ctrl #(
    .WIDTH        (W),
    .TAPS         (Taps),
    .CNT_W        (CW),
    .DEFAULT_SEED (4'd1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         start;
    logic [CW-1:0] len;
    logic         ready;
    logic         valid;
    logic [W-1:0] data;
    logic         done;
    logic         busy;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] got[$];
  logic [W-1:0] exp_q[$];
  bit           saw_done;
  logic [W-1:0] mseed, mlfsr, v, s;
  int           n, idx, uniq;
  bit           fin, rdy, ab;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] r);
    return {^(r & Taps), r[W-1:1]};
  endfunction

  function automatic vec_t mk(input logic st, input logic [CW-1:0] ln, input logic rd,
                              input logic vl, input logic [W-1:0] dt, input logic dn,
                              input logic bs);
    vec_t t;
    t.start = st; t.len = ln; t.ready = rd;
    t.valid = vl; t.data = dt; t.done = dn; t.busy = bs;
    return t;
  endfunction

  // Starts a burst with out_ready held high and gathers accepted beats.
  // Ends one cycle after done, back in idle.
  task automatic run_burst(input int len);
    got = {};
    saw_done = 1'b0;
    bus.start = 1'b1; bus.len = CW'(len); bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 300 && !saw_done; c++) begin
      if (bus.done) begin
        saw_done = 1'b1;
      end else begin
        if (bus.out_valid) got.push_back(bus.out_data);
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_seed = '0; bus.start = 1'b0; bus.len = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(bus.out_valid), 0);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check("rst.seed_err", 32'(bus.seed_err), 0);
    check("rst.data", 32'(bus.out_data), 1);
    reset = 1'b1;
    @(negedge clk);

    // Burst of 5 with ready high, then same burst with stalls.
    vecs.push_back(mk(1, 5, 1, 0, 4'd1,  0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd1,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd8,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd4,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd2,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd9,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'd12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd12, 0, 0));
    vecs.push_back(mk(1, 5, 0, 0, 4'd12, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 4'd1,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd8,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd8,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd8,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd4,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd4,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd2,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd2,  0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'd9,  0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 4'd9,  0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 4'd12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'd12, 0, 0));
    foreach (vecs[i]) begin
      check($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.data", i), 32'(bus.out_data), 32'(vecs[i].data));
      check($sformatf("vec%0d.done", i), 32'(bus.done), 32'(vecs[i].done));
      check($sformatf("vec%0d.busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      bus.start = vecs[i].start; bus.len = vecs[i].len; bus.out_ready = vecs[i].ready;
      @(negedge clk);
    end
    bus.start = 1'b0; bus.out_ready = 1'b0;

    // Zero seed rejected: error pulse, seed unchanged.
    bus.cfg_we = 1'b1; bus.cfg_seed = '0;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("zseed.err_pulse", 32'(bus.seed_err), 1);
    @(negedge clk);
    check("zseed.err_clear", 32'(bus.seed_err), 0);
    run_burst(2);
    check("zseed.done", 32'(saw_done), 1);
    check("zseed.nbeats", 32'(got.size()), 2);
    if (got.size() == 2) begin
      check("zseed.beat0", 32'(got[0]), 1);
      check("zseed.beat1", 32'(got[1]), 8);
    end

    // Valid seed write takes effect at the next start.
    bus.cfg_we = 1'b1; bus.cfg_seed = 4'b1010;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("seed10.err", 32'(bus.seed_err), 0);
    run_burst(1);
    check("seed10.nbeats", 32'(got.size()), 1);
    if (got.size() == 1) check("seed10.beat0", 32'(got[0]), 10);

    // len == 0: straight to done, LFSR untouched.
    mlfsr = lfsr_next(4'd10);
    bus.start = 1'b1; bus.len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("len0.done", 32'(bus.done), 1);
    check("len0.valid", 32'(bus.out_valid), 0);
    check("len0.data", 32'(bus.out_data), 32'(mlfsr));
    @(negedge clk);
    check("len0.done_clr", 32'(bus.done), 0);
    check("len0.valid2", 32'(bus.out_valid), 0);

    // Abort with the 3rd beat's handshake; a start mid-run is ignored.
    bus.start = 1'b1; bus.len = 8'd20; bus.out_ready = 1'b1;
    @(negedge clk);
    v = 4'd10;
    check("abort.beat0", 32'(bus.out_data), 32'(v));
    bus.start = 1'b1; bus.len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    v = lfsr_next(v);
    check("abort.beat1", 32'(bus.out_data), 32'(v));
    @(negedge clk);
    v = lfsr_next(v);
    check("abort.beat2", 32'(bus.out_data), 32'(v));
    check("abort.valid2", 32'(bus.out_valid), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort.valid", 32'(bus.out_valid), 0);
    check("abort.busy", 32'(bus.busy), 0);
    check("abort.done", 32'(bus.done), 0);
    check("abort.data", 32'(bus.out_data), 32'(lfsr_next(v)));
    @(negedge clk);
    check("abort.no_queue", 32'(bus.out_valid), 0);
    check("abort.done2", 32'(bus.done), 0);
    bus.out_ready = 1'b0;

    // Full period from seed 1.
    bus.cfg_we = 1'b1; bus.cfg_seed = 4'd1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    run_burst(15);
    check("period.done", 32'(saw_done), 1);
    check("period.nbeats", 32'(got.size()), 15);
    uniq = 0;
    for (int a = 1; a < 16; a++) begin
      for (int k = 0; k < got.size(); k++) begin
        if (got[k] == 4'(a)) begin
          uniq++;
          break;
        end
      end
    end
    check("period.distinct", 32'(uniq), 15);
    check("period.end_val", 32'(bus.out_data), 1);

    // Reset asserted mid-burst, away from a clock edge.
    bus.cfg_we = 1'b1; bus.cfg_seed = 4'd7;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    bus.start = 1'b1; bus.len = 8'd15; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.busy_before", 32'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst.valid", 32'(bus.out_valid), 0);
    check("midrst.busy", 32'(bus.busy), 0);
    check("midrst.done", 32'(bus.done), 0);
    check("midrst.data", 32'(bus.out_data), 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst.idle", 32'(bus.out_valid), 0);
    check("midrst.no_done", 32'(bus.done), 0);

    // Randomized bursts against a burst-level model.
    mseed = 4'd1;
    mlfsr = 4'd1;
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        s = 4'($urandom_range(0, 15));
        bus.cfg_we = 1'b1; bus.cfg_seed = s;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        check("rnd.seed_err", 32'(bus.seed_err), 32'(s == 4'd0));
        if (s != 4'd0) mseed = s;
      end
      n = $urandom_range(0, 40);
      exp_q = {};
      v = mseed;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(v);
        v = lfsr_next(v);
      end
      bus.start = 1'b1; bus.len = CW'(n);
      @(negedge clk);
      bus.start = 1'b0;
      if (n == 0) begin
        check("rnd.len0_done", 32'(bus.done), 1);
        check("rnd.len0_valid", 32'(bus.out_valid), 0);
        check("rnd.len0_data", 32'(bus.out_data), 32'(mlfsr));
        @(negedge clk);
        continue;
      end
      mlfsr = mseed;
      idx = 0;
      fin = 1'b0;
      for (int c = 0; c < 1000 && !fin; c++) begin
        check("rnd.valid", 32'(bus.out_valid), 1);
        check("rnd.data", 32'(bus.out_data), 32'(exp_q[idx]));
        rdy = ($urandom_range(0, 3) != 0);
        ab  = ($urandom_range(0, 29) == 0);
        bus.out_ready = rdy; bus.abort = ab;
        if (rdy) begin
          mlfsr = lfsr_next(exp_q[idx]);
          idx++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0; bus.abort = 1'b0;
        if (ab) begin
          check("rnd.abort_valid", 32'(bus.out_valid), 0);
          check("rnd.abort_done", 32'(bus.done), 0);
          check("rnd.abort_data", 32'(bus.out_data), 32'(mlfsr));
          fin = 1'b1;
        end else if (idx == n) begin
          check("rnd.done", 32'(bus.done), 1);
          check("rnd.done_valid", 32'(bus.out_valid), 0);
          check("rnd.done_data", 32'(bus.out_data), 32'(mlfsr));
          fin = 1'b1;
        end
      end
      if (!fin) check("rnd.timeout", 32'(fin), 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
